// File: rtl/store_rmw_seq.sv
// store_rmw_seq: read-modify-write sequencer merging partial stores (sd/sw/sh/sb) into 64-bit memory
// Optional read-wait timeout/abort enabled by defining STORE_RMW_TIMEOUT_EN.
module store_rmw_seq #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] mask;
    logic [1:0]        size;

    // Lanes taken from the store data; the rest of the doubleword keeps its old contents.
    assign mask = size == 2'd1 ? DATA_W'(64'hFFFF_FFFF) :
                  size == 2'd2 ? DATA_W'(64'hFFFF) :
                  size == 2'd3 ? DATA_W'(64'hFF) : '1;

`ifdef STORE_RMW_TIMEOUT_EN
    localparam int CW = RD_TIMEOUT > 255 ? $clog2(RD_TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt;
    logic          err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            data  <= '0;
            wbuf  <= '0;
            size  <= '0;
`ifdef STORE_RMW_TIMEOUT_EN
            cnt   <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr  <= req_addr;
                    data  <= req_data;
                    size  <= req_size;
                    wbuf  <= req_data;
                    state <= req_size == 2'd0 ? WRITE : RD_REQ;
                end
                RD_REQ: begin
                    state <= RD_WAIT;
`ifdef STORE_RMW_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                RD_WAIT: if (mem_rd_valid) begin
                    wbuf  <= (mem_rdata & ~mask) | (data & mask);
                    state <= WRITE;
                end
`ifdef STORE_RMW_TIMEOUT_EN
                else if (cnt == CW'(RD_TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                WRITE: state <= DONE;
                DONE: begin
                    state <= IDLE;
`ifdef STORE_RMW_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = rst_n & (state == IDLE);
    assign busy      = state != IDLE;
    assign mem_rd_en = state == RD_REQ;
    assign mem_wr_en = state == WRITE;
    assign done      = state == DONE;
    assign mem_addr  = addr;
    assign mem_wdata = state == WRITE ? wbuf : '0;
`ifdef STORE_RMW_TIMEOUT_EN
    assign err = (state == DONE) & err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_store_rmw_seq.sv
// tb_store_rmw_seq: scoreboard bench for store_rmw_seq; timeout scenario runs when STORE_RMW_TIMEOUT_EN is defined.
module tb_store_rmw_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rd_valid = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [127:0] sb[$];

    localparam logic [63:0] D   = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] OLD = 64'h1111_2222_3333_4444;

    store_rmw_seq #(.DATA_W(64), .ADDR_W(64), .RD_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [1:0] sz, input logic [63:0] old, input logic [63:0] d);
        case (sz)
            2'd0:    return d;
            2'd1:    return {old[63:32], d[31:0]};
            2'd2:    return {old[63:16], d[15:0]};
            default: return {old[63:8], d[7:0]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (sb.size() == 0) chk("unexp_wr", 64'd1, 64'd0);
            else begin
                logic [127:0] e;
                e = sb.pop_front();
                chk("wr_addr", mem_addr, e[127:64]);
                chk("wr_data", mem_wdata, e[63:0]);
            end
        end else if (rst_n) chk("wdata_idle", mem_wdata, 64'd0);
    end

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the edge back into IDLE.
    task automatic store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] old, input int k, input logic hold);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        sb.push_back({a, merge(sz, old, d)});
        @(negedge clk);
        chk("ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        req_valid = hold;
        if (sz != 2'd0) begin mem_rd_valid = 1'b1; mem_rdata = ~old; end
        @(negedge clk);
        chk("rd_en", mem_rd_en, 64'(sz != 2'd0));
        chk("wr_en_t1", mem_wr_en, 64'(sz == 2'd0));
        chk("ready_busy", req_ready, 0);
        if (sz != 2'd0) begin
            for (int i = 1; i <= k; i++) begin
                @(posedge clk); #1;
                mem_rd_valid = (i == k);
                mem_rdata = (i == k) ? old : ~old;
                @(negedge clk);
                chk("wait_wr", mem_wr_en, 0);
                chk("wait_rd", mem_rd_en, 0);
            end
            @(posedge clk); #1;
            mem_rd_valid = 1'b0; mem_rdata = '0;
            @(negedge clk);
            chk("wr_en", mem_wr_en, 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("done", done, 1);
        chk("err", err, 0);
        chk("done_wr", mem_wr_en, 0);
        @(posedge clk); #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd"}, mem_rd_en, 0);
        chk({tag, "_wr"}, mem_wr_en, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_addr", mem_addr, 0);
        @(posedge clk); #1;

        store(2'd0, 64'h100, D, OLD, 0, 1'b0);
        store(2'd1, 64'h108, D, OLD, 3, 1'b0);
        store(2'd2, 64'h110, D, OLD, 1, 1'b0);
        store(2'd3, 64'h118, D, OLD, 1, 1'b0);
        store(2'd1, 64'h120, 64'h0123_4567_89AB_CDEF, OLD, 2, 1'b1);
        store(2'd2, 64'h128, 64'hFEDC_BA98_7654_3210, 64'h5555_6666_7777_8888, 2, 1'b0);

        mem_rd_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            chk("spur_busy", busy, 0);
            chk("spur_ready", req_ready, 1);
            @(posedge clk); #1;
        end
        mem_rd_valid = 1'b0; mem_rdata = '0;
        store(2'd0, 64'h130, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 1'b0);

        req_valid = 1'b1; req_addr = 64'h200; req_data = D; req_size = 2'd1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 all_zero("mid_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 1);
        @(posedge clk); #1;
        mem_rd_valid = 1'b1; mem_rdata = OLD;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_nowr", mem_wr_en, 0);
            @(posedge clk); #1;
        end
        mem_rd_valid = 1'b0; mem_rdata = '0;

`ifdef STORE_RMW_TIMEOUT_EN
        req_valid = 1'b1; req_addr = 64'h300; req_data = D; req_size = 2'd1;
        @(negedge clk);
        chk("to_ready", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("to_rd_en", mem_rd_en, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_wait_wr", mem_wr_en, 0);
            chk("to_wait_done", done, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_wr", mem_wr_en, 0);
        @(posedge clk); #1;
`endif

        store(2'd3, 64'h140, 64'h0000_0000_0000_00A5, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
